// File: rtl/fsa15_sum_accumulator.sv
// Registered batch accumulator behind the 15x15 carry-skip adder: sums NUM_TERMS
// handshaked words, then holds the total until taken. Build option FSA15_ACC_SAT_EN saturates on overflow.
module fsa15_sum_accumulator #(
    parameter int NUM_TERMS = 4,
    parameter int ACC_W     = 20
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [15:0]      S,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] ACC,
    output logic             OUT_OVF,
    output logic [4:0]       CNT
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(NUM_TERMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       cnt_q, cnt_d;
    // Keeps IN_READY low while reset is held and until the first edge after release.
    logic             live_q;

    logic             take;
    logic             ovf_next;
    logic [ACC_W:0]   sum_ext;

    assign IN_READY  = live_q && (state_q == ST_ACCUM) && !CLR;
    assign take      = IN_VALID && IN_READY;
    assign sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'(S);
    assign ovf_next  = ovf_q || sum_ext[ACC_W];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        if (CLR) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (take) begin
                        cnt_d = cnt_q + 5'd1;
                        ovf_d = ovf_next;
`ifdef FSA15_ACC_SAT_EN
                        acc_d = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
                        acc_d = sum_ext[ACC_W-1:0];
`endif
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Handoff clears the batch; the next term waits one cycle for ACCUM.
                    if (OUT_READY) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    assign OUT_VALID = (state_q == ST_HOLD);
    assign ACC       = acc_q;
    assign OUT_OVF   = ovf_q;
    assign CNT       = cnt_q;

endmodule

// File: tb/tb_fsa15_sum_accumulator.sv
// Scoreboard bench for fsa15_sum_accumulator: three instances (4x20, 3x17, 1x20) share clock and reset.
module tb_fsa15_sum_accumulator;

    typedef struct {
        int          id;
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [2:0]      clr, in_valid, out_ready;
    logic [2:0]      in_ready, out_valid, ovf;
    logic [15:0]     s_in [3];
    logic [2:0][4:0] cnt;
    logic [19:0]     acc0;
    logic [16:0]     acc1;
    logic [19:0]     acc2;

    exp_t   sb[$];
    exp_t   e_mon;
    longint m_acc [3];
    int     m_cnt [3];
    bit     m_ovf [3];
    int     n_cmp, n_err;

    fsa15_sum_accumulator #(.NUM_TERMS(4), .ACC_W(20)) dut0 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr[0]), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .S(s_in[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .ACC(acc0),
        .OUT_OVF(ovf[0]), .CNT(cnt[0]));

    fsa15_sum_accumulator #(.NUM_TERMS(3), .ACC_W(17)) dut1 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr[1]), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .S(s_in[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .ACC(acc1),
        .OUT_OVF(ovf[1]), .CNT(cnt[1]));

    fsa15_sum_accumulator #(.NUM_TERMS(1), .ACC_W(20)) dut2 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr[2]), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
        .S(s_in[2]), .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]), .ACC(acc2),
        .OUT_OVF(ovf[2]), .CNT(cnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nt(input int k);
        case (k)
            0: return 4;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int wd(input int k);
        return (k == 1) ? 17 : 20;
    endfunction

    function automatic logic [31:0] acc_of(input int k);
        case (k)
            0: return 32'(acc0);
            1: return 32'(acc1);
            default: return 32'(acc2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int k);
        m_acc[k] = 0;
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
    endtask

    // Reference arithmetic: exact sum, then wrap or clamp against 2^ACC_W.
    task automatic model_accept(input int k, input logic [15:0] v);
        longint tot;
        longint lim;
        exp_t   e;
        lim = longint'(1) << wd(k);
        tot = m_acc[k] + longint'(v);
        if (tot >= lim) m_ovf[k] = 1'b1;
`ifdef FSA15_ACC_SAT_EN
        m_acc[k] = m_ovf[k] ? (lim - 1) : tot;
`else
        m_acc[k] = tot % lim;
`endif
        m_cnt[k]++;
        if (m_cnt[k] == nt(k)) begin
            e.id  = k;
            e.acc = 32'(m_acc[k]);
            e.ovf = m_ovf[k];
            sb.push_back(e);
            model_clear(k);
        end
    endtask

    // Offer one term after `gap` idle cycles; returns one time unit after the accept edge.
    task automatic send(input int k, input logic [15:0] v, input int gap);
        bit ok;
        in_valid[k] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b1;
        s_in[k]     = v;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready[k];
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
        if (ok) model_accept(k, v);
        else    check("send_timeout", 64'(in_ready[k]), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_acc"},   64'(acc_of(k)),   64'd0);
            check({tag, "_cnt"},   64'(cnt[k]),      64'd0);
            check({tag, "_ovf"},   64'(ovf[k]),      64'd0);
            check({tag, "_valid"}, 64'(out_valid[k]), 64'd0);
            check({tag, "_ready"}, 64'(in_ready[k]),  64'd0);
        end
    endtask

    task automatic assert_reset(input string tag);
        rst_n    = 1'b0;
        clr      = '0;
        in_valid = '0;
        for (int k = 0; k < 3; k++) model_clear(k);
        sb.delete();
        #1;
        check_zero(tag);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) check("rel_ready_low", 64'(in_ready[k]), 64'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check("rel_ready_high", 64'(in_ready[k]), 64'd1);
    endtask

    // Output side of the scoreboard: compare on every completed OUT handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", 64'(out_valid[k]), 64'd0);
                end else begin
                    e_mon = sb.pop_front();
                    check("out_id",  64'(k),         64'(e_mon.id));
                    check("out_acc", 64'(acc_of(k)), 64'(e_mon.acc));
                    check("out_ovf", 64'(ovf[k]),    64'(e_mon.ovf));
                    check("out_cnt", 64'(cnt[k]),    64'(nt(k)));
                end
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        clr       = '0;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            s_in[k] = '0;
            model_clear(k);
        end
        #2;
        check_zero("por");
        repeat (2) @(posedge clk);
        release_reset();

        // Back-to-back full-scale batch, then a 0xFFFF batch.
        out_ready[0] = 1'b1;
        repeat (4) send(0, 16'hFFFE, 0);
        check("basic_valid", 64'(out_valid[0]), 64'd1);
        check("basic_acc",   64'(acc_of(0)),    64'h3FFF8);
        check("basic_cnt",   64'(cnt[0]),       64'd4);
        check("basic_ovf",   64'(ovf[0]),       64'd0);
        @(posedge clk);
        #1;
        check("basic_ret_valid", 64'(out_valid[0]), 64'd0);
        check("basic_ret_acc",   64'(acc_of(0)),    64'd0);
        check("basic_ret_ready", 64'(in_ready[0]),  64'd1);
        repeat (4) send(0, 16'hFFFF, 0);
        @(posedge clk);
        #1;

        // Input gaps, then an output stall with a term offered during HOLD.
        out_ready[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(0, 16'(i), i);
            if (i < 4) begin
                check("stall_cnt", 64'(cnt[0]),    64'(i));
                check("stall_acc", 64'(acc_of(0)), 64'(m_acc[0]));
            end
        end
        in_valid[0] = 1'b1;
        s_in[0]     = 16'h0007;
        repeat (5) begin
            @(negedge clk);
            check("hold_acc",   64'(acc_of(0)),    64'h0000A);
            check("hold_ready", 64'(in_ready[0]),  64'd0);
            check("hold_valid", 64'(out_valid[0]), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release", 64'(out_valid[0]), 64'd0);

        // Overflow on the 17-bit instance, then a clean batch.
        out_ready[1] = 1'b1;
        repeat (3) send(1, 16'hFFFE, 0);
        check("ovf_flag", 64'(ovf[1]), 64'd1);
        @(posedge clk);
        #1;
        check("ovf_cleared",     64'(ovf[1]),    64'd0);
        check("ovf_acc_cleared", 64'(acc_of(1)), 64'd0);
        repeat (3) send(1, 16'h0001, 0);
        @(posedge clk);
        #1;

        // CLR mid-batch with a term offered in the same cycle.
        send(0, 16'h0001, 0);
        send(0, 16'h0002, 0);
        check("clr_pre_acc", 64'(acc_of(0)), 64'h3);
        clr[0]      = 1'b1;
        in_valid[0] = 1'b1;
        s_in[0]     = 16'h0100;
        @(negedge clk);
        check("clr_ready", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        clr[0]      = 1'b0;
        in_valid[0] = 1'b0;
        model_clear(0);
        check("clr_acc", 64'(acc_of(0)), 64'd0);
        check("clr_cnt", 64'(cnt[0]),    64'd0);
        repeat (4) send(0, 16'h0001, 0);
        @(posedge clk);
        #1;

        // CLR while holding a total: the total is discarded.
        out_ready[0] = 1'b0;
        repeat (4) send(0, 16'h0010, 0);
        check("clrh_valid", 64'(out_valid[0]), 64'd1);
        void'(sb.pop_back());
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        check("clrh_valid_drop", 64'(out_valid[0]), 64'd0);
        check("clrh_acc",        64'(acc_of(0)),    64'd0);
        out_ready[0] = 1'b1;

        // Asynchronous reset mid-batch, then during HOLD.
        send(0, 16'h0005, 0);
        send(0, 16'h0006, 0);
        #2;
        assert_reset("rst_mid");
        release_reset();
        repeat (4) send(0, 16'h0003, 0);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        repeat (4) send(0, 16'h0020, 0);
        check("rsth_valid", 64'(out_valid[0]), 64'd1);
        #2;
        assert_reset("rst_hold");
        release_reset();
        out_ready[0] = 1'b1;
        repeat (4) send(0, 16'h0021, 0);
        @(posedge clk);
        #1;

        // Single-term batches: accept and HOLD alternate.
        out_ready[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(2, 16'h1234, 0);
            check("nt1_bubble", 64'(in_ready[2]),  64'd0);
            check("nt1_valid",  64'(out_valid[2]), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
